// File: rtl/rr_packet_mux.sv
// N-to-1 packet egress mux: round-robin grant held for a whole packet,
// valid/ready on every port and a registered egress stage.
module rr_packet_mux #(
    parameter int N_PORTS    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = $clog2(N_PORTS)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [N_PORTS-1:0][DATA_WIDTH-1:0] ingress_data,
    input  logic [N_PORTS-1:0]                 ingress_valid,
    input  logic [N_PORTS-1:0]                 ingress_last,
    output logic [N_PORTS-1:0]                 ingress_ready,
    output logic [DATA_WIDTH-1:0]              egress_data,
    output logic                               egress_valid,
    output logic                               egress_last,
    input  logic                               egress_ready,
    output logic [IDX_WIDTH-1:0]               selected_ingress,
    output logic                               busy
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               state, state_nxt;
    logic [IDX_WIDTH-1:0] last_grant;
    logic [IDX_WIDTH-1:0] grant;
    logic [IDX_WIDTH-1:0] cand;
    logic                 grant_vld;
    logic                 accept;
    logic                 pkt_done;

    // Scan from furthest to nearest offset so the port right after
    // last_grant ends up as the winner.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int i = N_PORTS; i >= 1; i--) begin
            cand = IDX_WIDTH'((int'(last_grant) + i) % N_PORTS);
            if (ingress_valid[cand]) begin
                grant     = cand;
                grant_vld = 1'b1;
            end
        end
    end

    assign accept   = (state == LOCKED) && ingress_valid[selected_ingress]
                      && ingress_ready[selected_ingress];
    assign pkt_done = accept && ingress_last[selected_ingress];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            last_grant       <= IDX_WIDTH'(N_PORTS - 1);
            selected_ingress <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant_vld)
                selected_ingress <= grant;
            if (pkt_done)
                last_grant <= selected_ingress;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = LOCKED;
            LOCKED:  if (pkt_done)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Only the granted port may see ready, and only when the egress
    // register is empty or draining this cycle.
    always_comb begin
        ingress_ready = '0;
        busy          = (state == LOCKED);
        if (state == LOCKED)
            ingress_ready[selected_ingress] = !egress_valid || egress_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            egress_data  <= '0;
            egress_last  <= 1'b0;
            egress_valid <= 1'b0;
        end else if (accept) begin
            egress_data  <= ingress_data[selected_ingress];
            egress_last  <= ingress_last[selected_ingress];
            egress_valid <= 1'b1;
        end else if (egress_ready) begin
            egress_valid <= 1'b0;
        end
    end

endmodule

// File: doc/rr_packet_mux.md
Name: rr_packet_mux

Overview:
- Parametrised N-to-1 egress multiplexer for the packet switch.
- Selects one ingress port per packet using round-robin arbitration.
- Holds the grant until that packet's last beat, then rotates to the next requester.
- Carries valid/ready handshakes on every port and a registered egress stage, replacing the externally-steered combinational mux.

Parameters:
- N_PORTS, 4: number of ingress ports; must be >= 2.
- DATA_WIDTH, 16: beat width in bits.
- IDX_WIDTH, $clog2(N_PORTS): width of the port index.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ingress_data  in  [N_PORTS-1:0][DATA_WIDTH-1:0]  per-port beat data.
- ingress_valid  in  N_PORTS  per-port beat valid.
- ingress_last  in  N_PORTS  per-port end-of-packet flag, qualified by valid.
- ingress_ready  out  N_PORTS  per-port accept.
- egress_data  out  DATA_WIDTH  registered output beat.
- egress_valid  out  1  output beat valid.
- egress_last  out  1  output end-of-packet flag.
- egress_ready  in  1  downstream accept.
- selected_ingress  out  IDX_WIDTH  currently or most recently granted port.
- busy  out  1  high while in LOCKED.

Behaviour:
- State machine: IDLE and LOCKED.
- Pointer last_grant (IDX_WIDTH).

Reset (asynchronous, immediate):
- state=IDLE, last_grant=N_PORTS-1, selected_ingress=0, busy=0.
- egress_valid=0, egress_last=0, egress_data=0, ingress_ready=0.
- Reset mid-packet drops the packet; no partial beats are emitted afterwards.

IDLE:
- All ingress_ready=0.
- If any ingress_valid: grant the first valid port scanning (last_grant+1) mod N_PORTS upward with wrap.
- On the clock edge: selected_ingress<=grant, state<=LOCKED.
- If none valid, stay in IDLE.

LOCKED, granted port g:
- ingress_ready[g] = (!egress_valid || egress_ready). All other ready bits are 0.
- Acceptance = ingress_valid[g] && ingress_ready[g].
- On acceptance: egress_data<=ingress_data[g], egress_last<=ingress_last[g], egress_valid<=1.
- If no acceptance and egress_ready: egress_valid<=0.
- Accepted beat with ingress_last[g]=1: state<=IDLE, last_grant<=g.
- Valid drop on g mid-packet: stay LOCKED and wait. There is no timeout.

Timing and throughput:
- Latency: beat accepted at edge k appears on egress at cycle k+1.
- Full throughput of 1 beat/cycle within a packet while egress_ready=1.
- One arbitration bubble cycle per packet in IDLE.
- Backpressure: egress_ready=0 with egress_valid=1 holds egress_data, egress_last and egress_valid stable and forces ingress_ready[g]=0.

Edge cases:
- A single-beat packet (last=1 on first beat) returns to IDLE after that one beat.
- Simultaneous requests are resolved purely by rotating priority. Every requester is served within N_PORTS packets; no starvation.
- Wrap: last_grant=N_PORTS-1 searches from port 0.
- ingress_data, ingress_last and ingress_valid of non-granted ports are ignored.
- busy = (state==LOCKED).
- Egress drain in IDLE: egress_valid may still be 1 in IDLE while the final beat drains, and clears on egress_ready.

Test Plan:
1. Reset then single request: port 2 sends 3-beat packet 0xA1,0xA2,0xA3 (last on 3rd), egress_ready=1 -> selected_ingress=2 after 1 cycle; egress shows A1,A2,A3 on consecutive cycles, egress_last only on A3; busy falls after A3 accepted.
2. All 4 ports request continuously with 2-beat packets -> grant order 0,1,2,3,0; one idle arbitration cycle between packets; no interleaving of beats.
3. Backpressure: egress_ready=0 for 3 cycles mid-packet on port 1 beat 0x0055 -> egress_data holds 0x0055, egress_valid=1, ingress_ready[1]=0 throughout; transfer resumes with no loss or duplication.
4. Wrap and fairness: last_grant=3, ports 0 and 3 request -> port 0 granted; next packet goes to port 3.
5. Async reset asserted mid-packet (port 2, beat 2 of 4) -> outputs zero immediately, without a clock edge; after release, port 2's remaining beats start a new arbitration and port 0 has first priority.
6. Parameter sweep N_PORTS=8, DATA_WIDTH=32: port 7 then port 0 single-beat packets -> correct selected_ingress values 7, then 0; 32-bit data passes unchanged.
